// File: rtl/shift_add_mult_param_pkg.sv
// Shared types and constants for the parametrised shift-add multiplier.
package shift_add_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sam_state_t;

endpackage

// File: rtl/shift_add_mult_param_if.sv
// Operand / result handshake bundle for shift_add_mult_param.
// master = operand producer + result consumer, slave = multiplier.
interface shift_add_mult_param_if
  import shift_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     q;
  logic                 signed_md;
  logic                 busy;
  logic [2*WIDTH-1:0]   result;
  logic                 d_end;
  logic                 out_ready;

  modport master (
    output in_valid, b, q, signed_md, out_ready,
    input  in_ready, busy, result, d_end
  );

  modport slave (
    input  in_valid, b, q, signed_md, out_ready,
    output in_ready, busy, result, d_end
  );

endinterface

// File: rtl/shift_add_mult_param_abs.sv
// Combinational magnitude: |x| when sgn_en is set, x unchanged otherwise.
// The most negative value maps to 2^(WIDTH-1), which still fits WIDTH unsigned bits.
module shift_add_abs
  import shift_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic             sgn_en,
  output logic [WIDTH-1:0] abs_x
);

  // Negate only negative two's-complement inputs in signed mode
  always_comb begin
    abs_x = x;
    if (sgn_en && x[WIDTH-1]) begin
      abs_x = {WIDTH{1'b0}} - x;
    end else begin
      abs_x = x;
    end
  end

endmodule

// File: rtl/shift_add_mult_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned
// per operation, one product in flight, valid/ready on both sides.
// Optional macro SHIFT_ADD_EARLY_TERM_EN: leave BUSY as soon as the remaining
// multiplier bits are all zero (same results, data-dependent latency).
module shift_add_mult_param
  import shift_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_mult_param_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sam_state_t        state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplr_q, mplr_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     result_q, result_d;
  logic              d_end_q, d_end_d;

  logic [WIDTH-1:0]  abs_b_s;
  logic [WIDTH-1:0]  abs_q_s;
  logic [PW-1:0]     acc_next_s;
  logic              last_step_s;

  shift_add_abs #(.WIDTH(WIDTH)) u_abs_b (
    .x      (bus.b),
    .sgn_en (bus.signed_md),
    .abs_x  (abs_b_s)
  );

  shift_add_abs #(.WIDTH(WIDTH)) u_abs_q (
    .x      (bus.q),
    .sgn_en (bus.signed_md),
    .abs_x  (abs_q_s)
  );

  // Next-state and datapath: load in IDLE, one add/shift per BUSY edge, hold in DONE
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    result_d    = result_q;
    d_end_d     = d_end_q;
    acc_next_s  = acc_q;
    last_step_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d = {{WIDTH{1'b0}}, abs_b_s};
          mplr_d  = abs_q_s;
          acc_d   = {PW{1'b0}};
          cnt_d   = CNT_INIT;
          neg_d   = bus.signed_md & (bus.b[WIDTH-1] ^ bus.q[WIDTH-1]);
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        if (mplr_q[0]) begin
          acc_next_s = acc_q + mcand_q;
        end else begin
          acc_next_s = acc_q;
        end
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q - CNT_ONE;
        acc_d   = acc_next_s;
`ifdef SHIFT_ADD_EARLY_TERM_EN
        last_step_s = (cnt_d == {CNT_W{1'b0}}) || (mplr_d == {WIDTH{1'b0}});
`else
        last_step_s = (cnt_d == {CNT_W{1'b0}});
`endif
        if (last_step_s) begin
          // Sign is applied once on the magnitude product; -0 stays 0
          if (neg_q) begin
            result_d = {PW{1'b0}} - acc_next_s;
          end else begin
            result_d = acc_next_s;
          end
          d_end_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          d_end_d = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
        d_end_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= {PW{1'b0}};
      mplr_q   <= {WIDTH{1'b0}};
      acc_q    <= {PW{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      neg_q    <= 1'b0;
      result_q <= {PW{1'b0}};
      d_end_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      d_end_q  <= d_end_d;
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q == BUSY);
  assign bus.result   = result_q;
  assign bus.d_end    = d_end_q;

endmodule

// File: tb/tb_shift_add_mult_param.sv
// Self-checking bench: WIDTH=8 directed/handshake/reset scenarios and a
// WIDTH=16 random signed/unsigned sweep against an arithmetic reference.
module tb_shift_add_mult_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  shift_add_mult_param_if #(.WIDTH(8))  if8  ();
  shift_add_mult_param_if #(.WIDTH(16)) if16 ();

  shift_add_mult_param #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  shift_add_mult_param #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  // Reference product: interpret operands, multiply, keep 2w bits
  function automatic longint ref_prod(longint b, longint q, int w, bit sm);
    longint bv = b;
    longint qv = q;
    longint mask = (longint'(1) << (2 * w)) - 1;
    if (sm && bv[w-1]) bv = bv - (longint'(1) << w);
    if (sm && qv[w-1]) qv = qv - (longint'(1) << w);
    return (bv * qv) & mask;
  endfunction

  // Reference latency in edges after the accept edge
  function automatic int ref_lat(longint q, int w, bit sm);
    longint mag = q;
    int n = 1;
    if (sm && q[w-1]) mag = (longint'(1) << w) - q;
    for (int i = 0; i < w; i++) if (mag[i]) n = i + 1;
`ifdef SHIFT_ADD_EARLY_TERM_EN
    return n;
`else
    return (n > 0) ? w : w;
`endif
  endfunction

  function automatic logic rd_ready(int w);
    return (w == 8) ? if8.in_ready : if16.in_ready;
  endfunction
  function automatic logic rd_dend(int w);
    return (w == 8) ? if8.d_end : if16.d_end;
  endfunction
  function automatic logic rd_busy(int w);
    return (w == 8) ? if8.busy : if16.busy;
  endfunction
  function automatic longint rd_result(int w);
    return (w == 8) ? longint'(if8.result) : longint'(if16.result);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(int w, bit v, longint b, longint q, bit sm);
    if (w == 8) begin
      if8.in_valid = v; if8.b = b[7:0]; if8.q = q[7:0]; if8.signed_md = sm;
    end else begin
      if16.in_valid = v; if16.b = b[15:0]; if16.q = q[15:0]; if16.signed_md = sm;
    end
  endtask

  task automatic set_or(int w, bit v);
    if (w == 8) if8.out_ready = v;
    else        if16.out_ready = v;
  endtask

  // Wait for IDLE, present operands for one edge, then scramble inputs
  task automatic launch(int w, longint b, longint q, bit sm, string tag, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!rd_ready(w) && n < 50) begin step(); n++; end
    if (!rd_ready(w)) begin
      checks++; failures++; ok = 1'b0;
      $display("FAIL %s: in_ready never rose (got 0, need 1)", tag);
      return;
    end
    set_in(w, 1'b1, b, q, sm);
    step();
    set_in(w, 1'b0, longint'($urandom), longint'($urandom), 1'($urandom));
    checks++;
    if (rd_busy(w) !== 1'b1 || rd_ready(w) !== 1'b0) begin
      failures++;
      $display("FAIL %s accept: busy=%0b in_ready=%0b, need 1/0", tag, rd_busy(w), rd_ready(w));
    end
  endtask

  // Count edges until d_end, then check latency and product
  task automatic finish_op(int w, longint b, longint q, bit sm, string tag);
    int lat = 0;
    longint exp_p = ref_prod(b, q, w, sm);
    do begin step(); lat++; end while (!rd_dend(w) && lat < 40);
    checks++;
    if (!rd_dend(w)) begin
      failures++;
      $display("FAIL %s: d_end never rose within 40 edges", tag);
      return;
    end
    checks++;
    if (lat !== ref_lat(q, w, sm)) begin
      failures++;
      $display("FAIL %s latency: got %0d need %0d", tag, lat, ref_lat(q, w, sm));
    end
    checks++;
    if (rd_result(w) !== exp_p) begin
      failures++;
      $display("FAIL %s result: b=%0h q=%0h sm=%0b got %0h need %0h", tag, b, q, sm, rd_result(w), exp_p);
    end
  endtask

  task automatic consume(int w, string tag);
    set_or(w, 1'b1);
    step();
    set_or(w, 1'b0);
    checks++;
    if (rd_dend(w) !== 1'b0 || rd_ready(w) !== 1'b1) begin
      failures++;
      $display("FAIL %s consume: d_end=%0b in_ready=%0b, need 0/1", tag, rd_dend(w), rd_ready(w));
    end
  endtask

  task automatic run_op(int w, longint b, longint q, bit sm, string tag);
    bit ok;
    launch(w, b, q, sm, tag, ok);
    if (ok) begin
      finish_op(w, b, q, sm, tag);
      consume(w, tag);
    end
  endtask

  task automatic test_reset();
    set_in(8, 1'b0, 0, 0, 1'b0); set_or(8, 1'b0);
    set_in(16, 1'b0, 0, 0, 1'b0); set_or(16, 1'b0);
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    checks++;
    if (if8.d_end !== 1'b0 || if8.result !== 16'h0000 || if8.busy !== 1'b0 || if8.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset8: d_end=%0b result=%0h busy=%0b in_ready=%0b, need 0/0/0/1",
               if8.d_end, if8.result, if8.busy, if8.in_ready);
    end
    checks++;
    if (if16.d_end !== 1'b0 || if16.result !== 32'h0 || if16.busy !== 1'b0 || if16.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset16: d_end=%0b result=%0h busy=%0b in_ready=%0b, need 0/0/0/1",
               if16.d_end, if16.result, if16.busy, if16.in_ready);
    end
  endtask

  task automatic test_directed();
    run_op(8, 127, 201, 1'b0, "u127x201");
    run_op(8, 255, 255, 1'b0, "u255x255");
    run_op(8, 8'hFD, 5, 1'b1, "s-3x5");
    run_op(8, 8'h80, 8'h80, 1'b1, "s-128x-128");
    run_op(8, 8'h80, 8'h7F, 1'b1, "s-128x127");
    run_op(8, 200, 1, 1'b0, "u200x1");
    run_op(8, 8'hB5, 0, 1'b1, "s_x0");
    run_op(8, 0, 8'h9C, 1'b1, "s0_x");
    run_op(8, 3, 8'h80, 1'b0, "u3x128");
  endtask

  task automatic test_backpressure();
    bit ok;
    longint exp_p = ref_prod(13, 11, 8, 1'b0);
    launch(8, 13, 11, 1'b0, "bp", ok);
    if (!ok) return;
    finish_op(8, 13, 11, 1'b0, "bp");
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (if8.d_end !== 1'b1 || longint'(if8.result) !== exp_p || if8.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: d_end=%0b result=%0h in_ready=%0b, need 1/%0h/0",
                 i, if8.d_end, if8.result, if8.in_ready, exp_p);
      end
    end
    consume(8, "bp");
    step();
    checks++;
    if (longint'(if8.result) !== exp_p) begin
      failures++;
      $display("FAIL bp_result_hold: got %0h need %0h", if8.result, exp_p);
    end
    run_op(8, 99, 77, 1'b0, "bp_next");
  endtask

  task automatic test_coincident();
    bit ok;
    launch(8, 6, 7, 1'b0, "coin", ok);
    if (!ok) return;
    finish_op(8, 6, 7, 1'b0, "coin");
    set_in(8, 1'b1, 8'hF6, 9, 1'b1);
    set_or(8, 1'b1);
    step();
    set_or(8, 1'b0);
    checks++;
    if (if8.busy !== 1'b0 || if8.in_ready !== 1'b1 || if8.d_end !== 1'b0) begin
      failures++;
      $display("FAIL coin_not_accepted: busy=%0b in_ready=%0b d_end=%0b, need 0/1/0",
               if8.busy, if8.in_ready, if8.d_end);
    end
    step();
    set_in(8, 1'b0, 0, 0, 1'b0);
    checks++;
    if (if8.busy !== 1'b1) begin
      failures++;
      $display("FAIL coin_accept_next: busy=%0b need 1", if8.busy);
    end
    finish_op(8, 8'hF6, 9, 1'b1, "coin2");
    consume(8, "coin2");
  endtask

  task automatic test_mid_reset();
    bit ok;
    run_op(8, 7, 9, 1'b0, "pre_rst");
    launch(8, 250, 251, 1'b0, "mid_rst", ok);
    if (!ok) return;
    step(); step(); step();
    checks++;
    if (if8.busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst_busy: busy=%0b need 1", if8.busy);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if (if8.d_end !== 1'b0 || if8.result !== 16'h0000 || if8.busy !== 1'b0 || if8.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst_state: d_end=%0b result=%0h busy=%0b in_ready=%0b, need 0/0/0/1",
               if8.d_end, if8.result, if8.busy, if8.in_ready);
    end
    run_op(8, 8'hC3, 8'h5A, 1'b1, "post_rst");
  endtask

  task automatic test_random8();
    for (int i = 0; i < 100; i++) begin
      run_op(8, longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)), 1'($urandom), "rnd8");
    end
  endtask

  task automatic test_random16();
    for (int i = 0; i < 1000; i++) begin
      run_op(16, longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)), 1'($urandom), "rnd16");
    end
    run_op(16, 16'h8000, 16'h8000, 1'b1, "s16_min_sq");
    run_op(16, 16'hFFFF, 16'hFFFF, 1'b0, "u16_max_sq");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_coincident();
    test_mid_reset();
    test_random8();
    test_random16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
